// File: rtl/hazard_stall_ctrl.sv
// Load-use / mult-div hazard detection, branch and jump flush control,
// and a saturating stall-cycle counter for the 5-stage pipeline.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             ID_MdStart,
  input  logic             ID_MdRead,
  input  logic             EX_BranchTaken,
  input  logic             ID_Jump,
  output logic             PC_Hold,
  output logic             IFID_Hold,
  output logic             ID_Stall,
  output logic             IF_Flush,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MDW = $clog2(MD_LATENCY + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LATENCY);
  localparam logic [MDW-1:0] MD_ONE  = MDW'(1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [MDW-1:0]   mdcnt_q, mdcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_hit, rt_hit;
  logic lu, md, haz, md_go;

  assign MdBusy     = (state_q == S_BUSY);
  assign StallCount = cnt_q;

  always_comb begin
    rs_hit = ID_UseRs && (ID_rs == EX_WriteReg);
    rt_hit = ID_UseRt && (ID_rt == EX_WriteReg);
    lu     = EX_MemRead && (EX_WriteReg != 5'd0)
             && (rs_hit || rt_hit);
    md     = MdBusy && (ID_MdRead || ID_MdStart);
    haz    = lu || md;
    md_go  = ID_MdStart && !haz && !EX_BranchTaken;
  end

  // A taken branch squashes ID, so it outranks any hazard stall.
  always_comb begin
    PC_Hold   = 1'b0;
    IFID_Hold = 1'b0;
    ID_Stall  = 1'b0;
    IF_Flush  = 1'b0;
    if (!reset) begin
      if (EX_BranchTaken) begin
        IF_Flush = 1'b1;
        ID_Stall = 1'b1;
      end else if (haz) begin
        PC_Hold   = 1'b1;
        IFID_Hold = 1'b1;
        ID_Stall  = 1'b1;
      end else if (ID_Jump) begin
        IF_Flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mdcnt_d = mdcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (md_go) begin
          mdcnt_d = MD_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        mdcnt_d = mdcnt_q - MD_ONE;
        if (mdcnt_q == MD_ONE) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        mdcnt_d = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (haz && !EX_BranchTaken && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mdcnt_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mdcnt_q <= mdcnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table plus
// mult/div, jump, reset and counter saturation sequences.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WriteReg;
  logic       ID_UseRs, ID_UseRt, EX_MemRead;
  logic       ID_MdStart, ID_MdRead;
  logic       EX_BranchTaken, ID_Jump;

  logic        pc_hold, ifid_hold, id_stall, if_flush;
  logic        md_busy;
  logic [15:0] stall_cnt;

  logic        s_pc, s_ifid, s_stall, s_flush, s_busy;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_LATENCY(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .ID_MdStart(ID_MdStart), .ID_MdRead(ID_MdRead),
    .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
    .PC_Hold(pc_hold), .IFID_Hold(ifid_hold),
    .ID_Stall(id_stall), .IF_Flush(if_flush),
    .MdBusy(md_busy), .StallCount(stall_cnt)
  );

  hazard_stall_ctrl #(.MD_LATENCY(32), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .ID_MdStart(ID_MdStart), .ID_MdRead(ID_MdRead),
    .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
    .PC_Hold(s_pc), .IFID_Hold(s_ifid),
    .ID_Stall(s_stall), .IF_Flush(s_flush),
    .MdBusy(s_busy), .StallCount(s_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt, wreg;
    logic       use_rs, use_rt, memrd;
    logic       mdstart, mdread, br, jmp;
    logic [3:0] exp_out;
    int         inc;
  } vec_t;

  vec_t vecs[12];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] wreg,
    input logic ur, input logic ut, input logic mr,
    input logic ms, input logic md,
    input logic br, input logic jp,
    input logic [3:0] eo, input int inc);
    vec_t v;
    v.name = nm; v.rs = rs; v.rt = rt; v.wreg = wreg;
    v.use_rs = ur; v.use_rt = ut; v.memrd = mr;
    v.mdstart = ms; v.mdread = md; v.br = br; v.jmp = jp;
    v.exp_out = eo; v.inc = inc;
    return v;
  endfunction

  task automatic idle_in();
    ID_rs = 0; ID_rt = 0; EX_WriteReg = 0;
    ID_UseRs = 0; ID_UseRt = 0; EX_MemRead = 0;
    ID_MdStart = 0; ID_MdRead = 0;
    EX_BranchTaken = 0; ID_Jump = 0;
  endtask

  task automatic lu_in();
    idle_in();
    EX_MemRead = 1; EX_WriteReg = 5'd8;
    ID_rs = 5'd8; ID_UseRs = 1;
  endtask

  task automatic apply(input vec_t v);
    ID_rs = v.rs; ID_rt = v.rt; EX_WriteReg = v.wreg;
    ID_UseRs = v.use_rs; ID_UseRt = v.use_rt;
    EX_MemRead = v.memrd;
    ID_MdStart = v.mdstart; ID_MdRead = v.mdread;
    EX_BranchTaken = v.br; ID_Jump = v.jmp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {pc_hold, ifid_hold, id_stall, if_flush};
  endfunction

  initial begin
    // exp_out = {PC_Hold, IFID_Hold, ID_Stall, IF_Flush}
    vecs[0]  = mk("quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[1]  = mk("lu_rs", 8, 0, 8, 1, 0, 1, 0, 0, 0, 0, 4'b1110, 1);
    vecs[2]  = mk("lu_rt", 1, 9, 9, 0, 1, 1, 0, 0, 0, 0, 4'b1110, 1);
    vecs[3]  = mk("zero_reg", 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
    vecs[4]  = mk("rt_unused", 3, 9, 9, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    vecs[5]  = mk("no_load", 8, 0, 8, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    vecs[6]  = mk("jump", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 0);
    vecs[7]  = mk("jump_lu", 8, 0, 8, 1, 0, 1, 0, 0, 0, 1, 4'b1110, 1);
    vecs[8]  = mk("br_lu_md", 8, 0, 8, 1, 0, 1, 1, 0, 1, 0, 4'b0011, 0);
    vecs[9]  = mk("branch", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0011, 0);
    vecs[10] = mk("mfhi_idle", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0);
    vecs[11] = mk("br_jump", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0011, 0);

    reset = 1;
    lu_in();
    #3;
    chk("rst_outs", {28'd0, outs()}, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    idle_in();
    step();
    step();
    reset = 0;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_outs"}, {28'd0, outs()},
          {28'd0, vecs[i].exp_out});
      step();
      exp_cnt += vecs[i].inc;
      chk({vecs[i].name, "_cnt"}, {16'd0, stall_cnt}, exp_cnt);
      chk({vecs[i].name, "_busy"}, {31'd0, md_busy}, 32'd0);
    end

    // load-use stall lasts one cycle once the load has moved on
    lu_in();
    @(negedge clk);
    chk("lu1_stall", {28'd0, outs()}, 32'b1110);
    step();
    exp_cnt++;
    EX_MemRead = 0;
    @(negedge clk);
    chk("lu1_release", {28'd0, outs()}, 32'b0000);
    step();
    chk("lu1_cnt", {16'd0, stall_cnt}, exp_cnt);

    // jump held behind a stall, flushed once the stall clears
    lu_in();
    ID_Jump = 1;
    @(negedge clk);
    chk("jmp_wait", {28'd0, outs()}, 32'b1110);
    step();
    exp_cnt++;
    EX_MemRead = 0;
    @(negedge clk);
    chk("jmp_go", {28'd0, outs()}, 32'b0001);
    step();

    // mult/div start at edge T
    idle_in();
    ID_MdStart = 1;
    @(negedge clk);
    chk("md_start_busy", {31'd0, md_busy}, 32'd0);
    chk("md_start_outs", {28'd0, outs()}, 32'd0);
    step();
    for (int k = 1; k <= 32; k++) begin
      idle_in();
      if (k >= 5) begin
        ID_MdRead = 1;
        ID_MdStart = 1;
      end
      @(negedge clk);
      chk($sformatf("md_busy_T%0d", k), {31'd0, md_busy}, 32'd1);
      chk($sformatf("md_stall_T%0d", k), {28'd0, outs()},
          (k >= 5) ? 32'b1110 : 32'b0000);
      step();
      if (k >= 5) exp_cnt++;
    end
    chk("md_cnt_28", {16'd0, stall_cnt}, exp_cnt);
    // T+33: unit free, mfhi proceeds and the held start is accepted
    @(negedge clk);
    chk("md_free_busy", {31'd0, md_busy}, 32'd0);
    chk("md_free_outs", {28'd0, outs()}, 32'b0000);
    step();
    idle_in();
    @(negedge clk);
    chk("md_restart", {31'd0, md_busy}, 32'd1);
    chk("md_rel_cnt", {16'd0, stall_cnt}, exp_cnt);

    // async reset ten cycles into the second operation
    repeat (9) step();
    chk("md_pre_rst", {31'd0, md_busy}, 32'd1);
    lu_in();
    #2;
    reset = 1;
    #1;
    chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_mid_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_mid_outs", {28'd0, outs()}, 32'd0);
    step();
    reset = 0;
    exp_cnt = 0;

    // saturation on the 4-bit counter instance
    for (int k = 0; k < 20; k++) step();
    chk("sat_cnt4", {28'd0, s_cnt}, 32'd15);
    chk("sat_cnt16", {16'd0, stall_cnt}, 32'd20);
    chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
    step();
    chk("sat_hold", {28'd0, s_cnt}, 32'd15);
    chk("sat_cnt16_b", {16'd0, stall_cnt}, 32'd21);
    idle_in();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
